dco_param: RTL and testbench
============================

Name: dco_param

Overview:
Parametrised digitally controlled oscillator for the ADPLL, the successor to the fixed 5-bit DCO.
- Converts the loop-filter word (magnitude plus sign) into a half-period threshold and toggles dco_clk when a free-running counter reaches it.
- New relative to the 5-bit DCO: configurable widths; a control-update handshake with glitch-free application at half-period boundaries; enable with clean stop; saturation flags.

Parameters:
W, 8, width of ctrl and kdco
TW, 8, width of threshold, offset and half-period counter
KSHIFT, 1, right shift applied to ctrl*kdco (must be >=1)
TMIN, 1, minimum clamped threshold (1 <= TMIN < 2^TW)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous, active-low reset
en  in  1  oscillator enable
ctrl_valid  in  1  capture ctrl/ctrl_sign this cycle
ctrl  in  W  filter magnitude
ctrl_sign  in  1  1 = raise threshold (slower), 0 = lower threshold
kdco  in  W  DCO gain
thresh_val  in  TW  nominal threshold
dco_offset  in  TW  additive threshold offset
dco_clk  out  1  oscillator output
half_tick  out  1  one-cycle pulse on each dco_clk toggle
upd_ack  out  1  one-cycle pulse when a captured ctrl is applied
sat_hi  out  1  current threshold clamped at 2^TW-1
sat_lo  out  1  current threshold clamped at TMIN
running  out  1  state != IDLE

Behaviour:
- Reset (async, reset_n=0):
  - Registers: state=IDLE, counter=0, ctrl_p=0, sign_p=0, dirty=0, thresh_q=0, frac_acc=0.
  - Outputs: dco_clk=0, half_tick=0, upd_ack=0, sat_hi=0, sat_lo=0.
- Capture:
  - On ctrl_valid: ctrl_p<=ctrl, sign_p<=ctrl_sign, dirty<=1. Last capture wins.
  - Captures are always accepted; there is no ready signal.
- Threshold (combinational, from registered ctrl_p/sign_p):
  - prod = ctrl_p*kdco (2W bits); ph = prod>>KSHIFT.
  - s = thresh_val + dco_offset + (sign_p ? +ph : -ph), computed signed at 2W+2 bits with no wrap.
  - t_next = clamp(s, TMIN, 2^TW-1). Flags: hi_next = (s > 2^TW-1), lo_next = (s < TMIN).
- Load event: whenever thresh_q is loaded, sat_hi/sat_lo take hi_next/lo_next in the same edge.
- FSM states: IDLE, RUN, STOP.
  - IDLE: counter=0, dco_clk=0.
    - en=1 → RUN, thresh_q<=t_next, counter<=0.
    - If dirty, upd_ack pulses and dirty clears (unless ctrl_valid is also asserted).
  - RUN: counter increments each cycle. When counter>=thresh_q (toggle event):
    - dco_clk flips, half_tick=1, counter<=0, thresh_q<=t_next.
    - If dirty: upd_ack=1 and dirty<=0, except that a ctrl_valid in the same cycle keeps dirty=1. That value is applied at the next toggle.
    - Half-period = thresh_q+1 cycles. First rising edge occurs thresh_q+1 cycles after entering RUN.
  - en=0 in RUN:
    - dco_clk=0 → IDLE at the next edge.
    - dco_clk=1 → STOP.
  - STOP: counts as in RUN.
    - At the toggle event dco_clk falls → IDLE.
    - en=1 in STOP → RUN with no disturbance to counter or dco_clk.
- Glitch-free update: thresh_q never changes mid half-period. Changes to kdco, thresh_val or dco_offset also take effect only at a load event.
- counter is TW bits wide; it cannot wrap, since thresh_q <= 2^TW-1.

Optional Feature:
DCO_FRAC_EN:
- Defined: frac = prod[KSHIFT-1:0] is accumulated into KSHIFT-bit frac_acc at each toggle event (signed by sign_p: add when sign_p=1, subtract when 0).
  - Carry (sign_p=1): next half-period gets +1 cycle; saturates at 2^TW-1.
  - Borrow (sign_p=0): next half-period gets -1 cycle; floors at TMIN.
  - frac_acc is cleared on reset and on entry to IDLE.
- Undefined: the fractional bits are discarded and frac_acc does not exist.

Test Plan:
1. thresh_val=10, dco_offset=2, ctrl=0, en=1 → T=12, half_tick every 13 cycles, dco_clk period 26, sat flags 0.
2. ctrl=4, kdco=3, ctrl_sign=1, valid mid-half-period → current half stays 13 cycles; upd_ack at that toggle; subsequent halves 19 cycles. Then ctrl_sign=0 → halves 7 cycles.
3. thresh_val=250, dco_offset=10, ctrl=0 → T=255, sat_hi=1. Then thresh_val=10, dco_offset=2, ctrl=20, kdco=20, sign=0 → T=TMIN=1, sat_lo=1, half-period 2.
4. en dropped while dco_clk=1 → dco_clk falls at its scheduled edge, then stays 0, running=0. en dropped while dco_clk=0 → IDLE next edge.
5. reset_n low mid high-half → dco_clk=0 and all flags 0 immediately, without waiting for a clock edge. After release with en=1 → first rise after T+1 cycles.
6. DCO_FRAC_EN, thresh_val=10, dco_offset=0, ctrl=1, kdco=1, sign=1 → half-periods alternate 11/12 cycles. Without the macro → constant 11.

Source files
------------

// File: rtl/dco_param.sv
// ---------------------------------------------------------------------------
// dco_param : parametrised digitally controlled oscillator for the ADPLL.
//
// The loop-filter word (magnitude plus sign) is scaled by the DCO gain,
// offset around a nominal threshold and clamped. The result is the
// half-period threshold. A free-running counter toggles o_dco_clk each time
// it reaches that threshold. Control updates are captured at any time and
// only applied at half-period boundaries, so the output never glitches.
//
// Optional feature macro: DCO_FRAC_EN
//   When defined, the bits shifted out of ctrl*kdco are accumulated at every
//   toggle. A carry stretches the next half-period by one cycle and a borrow
//   shortens it by one cycle, which gives fractional average periods.
//
// Parameters:
//   W      width of ctrl and kdco
//   TW     width of threshold, offset and half-period counter
//   KSHIFT right shift applied to ctrl*kdco (>= 1)
//   TMIN   smallest threshold the clamp allows (1 <= TMIN < 2^TW)
//
// Ports:
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   i_en           oscillator enable
//   i_ctrl_valid   capture i_ctrl / i_ctrl_sign this cycle
//   i_ctrl         filter magnitude
//   i_ctrl_sign    1 = raise threshold (slower), 0 = lower threshold
//   i_kdco         DCO gain
//   i_thresh_val   nominal threshold
//   i_dco_offset   additive threshold offset
//   o_dco_clk      oscillator output
//   o_half_tick    one-cycle pulse on each o_dco_clk toggle
//   o_upd_ack      one-cycle pulse when a captured ctrl is applied
//   o_sat_hi       current threshold clamped at 2^TW-1
//   o_sat_lo       current threshold clamped at TMIN
//   o_running      oscillator is not idle
// ---------------------------------------------------------------------------
module dco_param #(
    parameter int W      = 8,
    parameter int TW     = 8,
    parameter int KSHIFT = 1,
    parameter int TMIN   = 1
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_en,
    input  logic          i_ctrl_valid,
    input  logic [W-1:0]  i_ctrl,
    input  logic          i_ctrl_sign,
    input  logic [W-1:0]  i_kdco,
    input  logic [TW-1:0] i_thresh_val,
    input  logic [TW-1:0] i_dco_offset,
    output logic          o_dco_clk,
    output logic          o_half_tick,
    output logic          o_upd_ack,
    output logic          o_sat_hi,
    output logic          o_sat_lo,
    output logic          o_running
);

    localparam int PW = 2 * W;
    // Signed sum width: wide enough that thresh+offset+/-ph never wraps.
    localparam int SW = ((PW > TW) ? PW : TW) + 2;

    localparam logic signed [SW-1:0] S_MAX = {{(SW-TW){1'b0}}, {TW{1'b1}}};
    localparam logic signed [SW-1:0] S_MIN = SW'(TMIN);
    localparam logic [TW-1:0]        T_MAX = {TW{1'b1}};
    localparam logic [TW-1:0]        T_MIN = TW'(TMIN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [TW-1:0]  r_counter;
    logic [TW-1:0]  w_counter_next;
    logic [W-1:0]   r_ctrl_p;
    logic           r_sign_p;
    logic           r_dirty;
    logic           w_dirty_next;
    logic [TW-1:0]  r_thresh_q;
    logic [TW-1:0]  w_thresh_next;
    logic           r_dco;
    logic           w_dco_next;
    logic           r_half_tick;
    logic           w_half_next;
    logic           r_upd_ack;
    logic           w_ack_next;
    logic           r_sat_hi;
    logic           w_sat_hi_next;
    logic           r_sat_lo;
    logic           w_sat_lo_next;
    logic           w_apply;
    logic           w_toggle;

    logic [PW-1:0]        w_prod;
    logic [PW-1:0]        w_ph;
    logic [SW-1:0]        w_base;
    logic [SW-1:0]        w_phx;
    logic signed [SW-1:0] w_sum;
    logic                 w_hi_next;
    logic                 w_lo_next;
    logic [TW-1:0]        w_t_next;
    logic [TW-1:0]        w_t_toggle;

    // Threshold candidate, always derived from the registered control word so
    // that it only reaches r_thresh_q at a load event.
    assign w_prod = {{W{1'b0}}, r_ctrl_p} * {{W{1'b0}}, i_kdco};
    assign w_ph   = w_prod >> KSHIFT;
    assign w_base = SW'(i_thresh_val) + SW'(i_dco_offset);
    assign w_phx  = SW'(w_ph);
    assign w_sum  = r_sign_p ? $signed(w_base + w_phx) : $signed(w_base - w_phx);

    assign w_hi_next = (w_sum > S_MAX);
    assign w_lo_next = (w_sum < S_MIN);
    assign w_t_next  = w_hi_next ? T_MAX :
                       w_lo_next ? T_MIN : w_sum[TW-1:0];

`ifdef DCO_FRAC_EN
    logic [KSHIFT-1:0] r_frac_acc;
    logic [KSHIFT-1:0] w_frac_next;
    logic [KSHIFT:0]   w_frac_add;
    logic [KSHIFT:0]   w_frac_sub;

    assign w_frac_add = {1'b0, r_frac_acc} + {1'b0, w_prod[KSHIFT-1:0]};
    assign w_frac_sub = {1'b0, r_frac_acc} - {1'b0, w_prod[KSHIFT-1:0]};

    // A carry (or borrow) out of the accumulator nudges the half-period that
    // starts at this toggle by one cycle, still honouring the clamp limits.
    always_comb begin
        w_t_toggle = w_t_next;
        if (r_sign_p && w_frac_add[KSHIFT] && (w_t_next != T_MAX))
            w_t_toggle = w_t_next + TW'(1);
        else if (!r_sign_p && w_frac_sub[KSHIFT] && (w_t_next > T_MIN))
            w_t_toggle = w_t_next - TW'(1);
    end

    // Accumulator restarts from zero whenever the oscillator goes idle.
    always_comb begin
        w_frac_next = r_frac_acc;
        if (w_state_next == IDLE)
            w_frac_next = '0;
        else if (w_toggle)
            w_frac_next = r_sign_p ? w_frac_add[KSHIFT-1:0] : w_frac_sub[KSHIFT-1:0];
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_frac_acc <= '0;
        else
            r_frac_acc <= w_frac_next;
    end
`else
    assign w_t_toggle = w_t_next;
`endif

    // Next-state logic. Every load of r_thresh_q also refreshes the
    // saturation flags so they always describe the active threshold.
    always_comb begin
        w_state_next   = r_state;
        w_counter_next = r_counter;
        w_dco_next     = r_dco;
        w_thresh_next  = r_thresh_q;
        w_sat_hi_next  = r_sat_hi;
        w_sat_lo_next  = r_sat_lo;
        w_half_next    = 1'b0;
        w_ack_next     = 1'b0;
        w_apply        = 1'b0;
        w_toggle       = 1'b0;
        w_dirty_next   = i_ctrl_valid ? 1'b1 : r_dirty;

        case (r_state)
            IDLE: begin
                w_counter_next = '0;
                w_dco_next     = 1'b0;
                w_apply        = 1'b1;
                if (i_en) begin
                    w_state_next  = RUN;
                    w_thresh_next = w_t_next;
                    w_sat_hi_next = w_hi_next;
                    w_sat_lo_next = w_lo_next;
                end
            end
            RUN, STOP: begin
                if ((r_state == RUN) && !i_en && !r_dco) begin
                    // Output already low: stop straight away.
                    w_state_next   = IDLE;
                    w_counter_next = '0;
                    w_dco_next     = 1'b0;
                end else begin
                    w_counter_next = r_counter + TW'(1);
                    w_state_next   = i_en ? RUN : STOP;
                    if (r_counter >= r_thresh_q) begin
                        w_toggle       = 1'b1;
                        w_apply        = 1'b1;
                        w_dco_next     = ~r_dco;
                        w_half_next    = 1'b1;
                        w_counter_next = '0;
                        w_thresh_next  = w_t_toggle;
                        w_sat_hi_next  = w_hi_next;
                        w_sat_lo_next  = w_lo_next;
                        // Disabled while high: this toggle is the falling
                        // edge that finishes the clean stop.
                        if (!i_en && r_dco)
                            w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_counter_next = '0;
                w_dco_next     = 1'b0;
            end
        endcase

        // A capture arriving in the same cycle as an apply stays pending.
        if (w_apply && r_dirty) begin
            w_ack_next   = 1'b1;
            w_dirty_next = i_ctrl_valid;
        end
    end

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= IDLE;
            r_counter   <= '0;
            r_ctrl_p    <= '0;
            r_sign_p    <= 1'b0;
            r_dirty     <= 1'b0;
            r_thresh_q  <= '0;
            r_dco       <= 1'b0;
            r_half_tick <= 1'b0;
            r_upd_ack   <= 1'b0;
            r_sat_hi    <= 1'b0;
            r_sat_lo    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_counter   <= w_counter_next;
            r_dirty     <= w_dirty_next;
            r_thresh_q  <= w_thresh_next;
            r_dco       <= w_dco_next;
            r_half_tick <= w_half_next;
            r_upd_ack   <= w_ack_next;
            r_sat_hi    <= w_sat_hi_next;
            r_sat_lo    <= w_sat_lo_next;
            if (i_ctrl_valid) begin
                r_ctrl_p <= i_ctrl;
                r_sign_p <= i_ctrl_sign;
            end
        end
    end

    assign o_dco_clk   = r_dco;
    assign o_half_tick = r_half_tick;
    assign o_upd_ack   = r_upd_ack;
    assign o_sat_hi    = r_sat_hi;
    assign o_sat_lo    = r_sat_lo;
    assign o_running   = (r_state != IDLE);

endmodule

// File: tb/tb_dco_param.sv
// ---------------------------------------------------------------------------
// tb_dco_param : self-checking bench for dco_param (default parameters).
//
// Expected half-period lengths are queued as each directed step is driven and
// popped when the DUT reports the matching half_tick. Flags and levels are
// compared directly at the points where they must hold. Honours DCO_FRAC_EN
// when choosing the expected fractional pattern.
// ---------------------------------------------------------------------------
module tb_dco_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       en;
    logic       ctrl_valid;
    logic [7:0] ctrl;
    logic       ctrl_sign;
    logic [7:0] kdco;
    logic [7:0] thresh_val;
    logic [7:0] dco_offset;
    logic       dco_clk;
    logic       half_tick;
    logic       upd_ack;
    logic       sat_hi;
    logic       sat_lo;
    logic       running;

    int checks   = 0;
    int failures = 0;
    int expQ[$];

    always #5 clk = ~clk;

    dco_param dut (
        .i_clk        (clk),
        .i_reset_n    (reset_n),
        .i_en         (en),
        .i_ctrl_valid (ctrl_valid),
        .i_ctrl       (ctrl),
        .i_ctrl_sign  (ctrl_sign),
        .i_kdco       (kdco),
        .i_thresh_val (thresh_val),
        .i_dco_offset (dco_offset),
        .o_dco_clk    (dco_clk),
        .o_half_tick  (half_tick),
        .o_upd_ack    (upd_ack),
        .o_sat_hi     (sat_hi),
        .o_sat_lo     (sat_lo),
        .o_running    (running)
    );

    // Compare one observed value against its expectation.
    task automatic checkOutput(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive the static configuration inputs.
    task automatic applyStimulus(input logic e, input logic [7:0] tv,
                                 input logic [7:0] off, input logic [7:0] k);
        en         = e;
        thresh_val = tv;
        dco_offset = off;
        kdco       = k;
    endtask

    // One-cycle capture strobe; consumes one negedge.
    task automatic pulseValid(input logic [7:0] c, input logic s);
        ctrl       = c;
        ctrl_sign  = s;
        ctrl_valid = 1'b1;
        @(negedge clk);
        ctrl_valid = 1'b0;
    endtask

    // Cycles until the next half_tick; -1 when none arrives in time.
    task automatic measureHalf(output int len);
        int n;
        n   = 0;
        len = -1;
        while (n < 600) begin
            @(negedge clk);
            n++;
            if (half_tick === 1'b1) begin
                len = n;
                break;
            end
        end
    endtask

    // Wait (bounded) for running to reach a level, then check it.
    task automatic waitRunning(input logic want, input string tag);
        int n;
        n = 0;
        while ((running !== want) && (n < 600)) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, int'(running), int'(want));
    endtask

    // Pop every queued expectation against successive half-periods.
    task automatic drainHalves(input string tag);
        int len;
        int exp;
        while (expQ.size() > 0) begin
            exp = expQ.pop_front();
            measureHalf(len);
            checkOutput(tag, len, exp);
        end
    endtask

    initial begin
        int len;
        int ticks;

        reset_n    = 1'b0;
        ctrl_valid = 1'b0;
        ctrl       = 8'd0;
        ctrl_sign  = 1'b0;
        applyStimulus(1'b0, 8'd10, 8'd2, 8'd0);
        repeat (2) @(negedge clk);

        checkOutput("rst_dco_clk", int'(dco_clk), 0);
        checkOutput("rst_half_tick", int'(half_tick), 0);
        checkOutput("rst_upd_ack", int'(upd_ack), 0);
        checkOutput("rst_sat_hi", int'(sat_hi), 0);
        checkOutput("rst_sat_lo", int'(sat_lo), 0);
        checkOutput("rst_running", int'(running), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Nominal threshold 12: every half lasts 13 cycles.
        $display("[TB] step 1: nominal threshold");
        en = 1'b1;
        waitRunning(1'b1, "t1_running");
        expQ.push_back(13);
        measureHalf(len);
        checkOutput("t1_first_half", len, expQ.pop_front());
        checkOutput("t1_dco_high", int'(dco_clk), 1);
        expQ.push_back(13);
        expQ.push_back(13);
        drainHalves("t1_half");
        checkOutput("t1_sat_hi", int'(sat_hi), 0);
        checkOutput("t1_sat_lo", int'(sat_lo), 0);

        // Positive correction mid-half: 12 + (4*3>>1) = 18.
        $display("[TB] step 2: control update");
        kdco = 8'd3;
        repeat (4) @(negedge clk);
        pulseValid(8'd4, 1'b1);
        expQ.push_back(13);
        measureHalf(len);
        checkOutput("t2_current_half", len + 5, expQ.pop_front());
        checkOutput("t2_upd_ack", int'(upd_ack), 1);
        expQ.push_back(19);
        measureHalf(len);
        checkOutput("t2_raised_half", len, expQ.pop_front());
        checkOutput("t2_no_ack", int'(upd_ack), 0);
        repeat (3) @(negedge clk);
        pulseValid(8'd4, 1'b0);
        expQ.push_back(19);
        measureHalf(len);
        checkOutput("t2_pending_half", len + 4, expQ.pop_front());
        expQ.push_back(7);
        expQ.push_back(7);
        drainHalves("t2_lowered_half");

        // Saturation high (260 -> 255), then low (12 - 200 -> TMIN).
        $display("[TB] step 3: saturation");
        applyStimulus(1'b1, 8'd250, 8'd10, 8'd3);
        pulseValid(8'd0, 1'b1);
        expQ.push_back(7);
        measureHalf(len);
        checkOutput("t3_glitch_free", len + 1, expQ.pop_front());
        checkOutput("t3_sat_hi", int'(sat_hi), 1);
        checkOutput("t3_sat_lo_clear", int'(sat_lo), 0);
        applyStimulus(1'b1, 8'd10, 8'd2, 8'd20);
        pulseValid(8'd20, 1'b0);
        expQ.push_back(256);
        measureHalf(len);
        checkOutput("t3_max_half", len + 1, expQ.pop_front());
        checkOutput("t3_sat_lo", int'(sat_lo), 1);
        checkOutput("t3_sat_hi_clear", int'(sat_hi), 0);
        expQ.push_back(2);
        expQ.push_back(2);
        drainHalves("t3_min_half");

        // Clean stop while high, then immediate stop while low.
        $display("[TB] step 4: enable handling");
        pulseValid(8'd0, 1'b1);
        expQ.push_back(2);
        measureHalf(len);
        checkOutput("t4_restore_half", len + 1, expQ.pop_front());
        expQ.push_back(13);
        drainHalves("t4_half");
        if (dco_clk !== 1'b1) begin
            expQ.push_back(13);
            drainHalves("t4_extra_half");
        end
        repeat (3) @(negedge clk);
        en = 1'b0;
        expQ.push_back(13);
        measureHalf(len);
        checkOutput("t4_stop_edge", len + 3, expQ.pop_front());
        checkOutput("t4_stop_dco_low", int'(dco_clk), 0);
        checkOutput("t4_stop_idle", int'(running), 0);
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (half_tick === 1'b1) ticks++;
        end
        checkOutput("t4_quiet_ticks", ticks, 0);
        checkOutput("t4_quiet_dco", int'(dco_clk), 0);
        en = 1'b1;
        waitRunning(1'b1, "t4_restart");
        expQ.push_back(13);
        expQ.push_back(13);
        drainHalves("t4_restart_half");
        checkOutput("t4_low_phase", int'(dco_clk), 0);
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checkOutput("t4_low_stop_idle", int'(running), 0);
        checkOutput("t4_low_stop_dco", int'(dco_clk), 0);

        // Asynchronous reset in the high half.
        $display("[TB] step 5: async reset");
        en = 1'b1;
        waitRunning(1'b1, "t5_running");
        expQ.push_back(13);
        drainHalves("t5_half");
        checkOutput("t5_dco_high", int'(dco_clk), 1);
        repeat (3) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("t5_async_dco", int'(dco_clk), 0);
        checkOutput("t5_async_tick", int'(half_tick), 0);
        checkOutput("t5_async_sat_hi", int'(sat_hi), 0);
        checkOutput("t5_async_sat_lo", int'(sat_lo), 0);
        checkOutput("t5_async_running", int'(running), 0);
        @(negedge clk);
        reset_n = 1'b1;
        waitRunning(1'b1, "t5_rerun");
        expQ.push_back(13);
        drainHalves("t5_first_rise");
        checkOutput("t5_rise", int'(dco_clk), 1);

        // Fractional dithering: prod = 1, ph = 0, T = 10.
        $display("[TB] step 6: fractional bits");
        en = 1'b0;
        waitRunning(1'b0, "t6_idle");
        applyStimulus(1'b0, 8'd10, 8'd0, 8'd1);
        pulseValid(8'd1, 1'b1);
        en = 1'b1;
        waitRunning(1'b1, "t6_running");
`ifdef DCO_FRAC_EN
        expQ.push_back(11);
        expQ.push_back(11);
        expQ.push_back(12);
        expQ.push_back(11);
        expQ.push_back(12);
`else
        for (int i = 0; i < 5; i++) expQ.push_back(11);
`endif
        drainHalves("t6_frac_half");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
